// File: rtl/mm_timer_pkg.sv
// Shared definitions for the mm_timer slice: ctrl bit positions,
// config word indices and the timer state encoding.
package mm_timer_pkg;

    localparam int unsigned CTRL_EN       = 0;
    localparam int unsigned CTRL_PERIODIC = 1;
    localparam int unsigned CTRL_IRQ_EN   = 2;

    localparam int unsigned CFG_CTRL      = 0;
    localparam int unsigned CFG_PRESCALE  = 1;
    localparam int unsigned CFG_COMPARE   = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } timer_state_t;

endpackage

// File: rtl/mm_timer_prescaler.sv
// Prescaler for mm_timer: counts 0..prescale while enabled and raises a
// one-cycle tick on the terminal value, giving a period of prescale+1 clocks.
module mm_timer_prescaler
    import mm_timer_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  enable,
    input  logic [DATA_WIDTH-1:0] prescale,
    output logic                  tick
);

    logic [DATA_WIDTH-1:0] preCnt;

    assign tick = enable && (preCnt == prescale);

    // Prescaler counter: cleared while disabled and on every tick.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            preCnt <= '0;
        end else if (!enable || tick) begin
            preCnt <= '0;
        end else begin
            preCnt <= preCnt + DATA_WIDTH'(1);
        end
    end

endmodule

// File: rtl/mm_timer.sv
// Timer/compare peripheral fed by the packed words of a 3-entry register
// block (ctrl, prescale, compare). Provides a free-running count, a running
// flag and a sticky interrupt.
// Optional input capture is enabled with MM_TIMER_CAPTURE_EN.
module mm_timer
    import mm_timer_pkg::*;
#(
    parameter int unsigned DATA_WIDTH   = 32,
    parameter int unsigned NUM_CFG_REGS = 3
) (
    input  logic                               clock,
    input  logic                               reset,
    input  logic [DATA_WIDTH*NUM_CFG_REGS-1:0] config_regs,
    input  logic                               irq_clear,
`ifdef MM_TIMER_CAPTURE_EN
    input  logic                               capture,
    output logic [DATA_WIDTH-1:0]              capture_value,
`endif
    output logic [DATA_WIDTH-1:0]              count,
    output logic                               running,
    output logic                               irq
);

    logic [DATA_WIDTH-1:0] ctrlWord;
    logic [DATA_WIDTH-1:0] prescaleWord;
    logic [DATA_WIDTH-1:0] compareWord;
    logic                  en;
    logic                  periodic;
    logic                  irqEn;
    logic                  unusedCtrl;

    timer_state_t          state;
    timer_state_t          stateNext;
    logic [DATA_WIDTH-1:0] countNext;
    logic                  irqNext;
    logic                  match;
    logic                  tick;
    logic                  runActive;

    assign ctrlWord     = config_regs[CFG_CTRL*DATA_WIDTH     +: DATA_WIDTH];
    assign prescaleWord = config_regs[CFG_PRESCALE*DATA_WIDTH +: DATA_WIDTH];
    assign compareWord  = config_regs[CFG_COMPARE*DATA_WIDTH  +: DATA_WIDTH];

    assign en         = ctrlWord[CTRL_EN];
    assign periodic   = ctrlWord[CTRL_PERIODIC];
    assign irqEn      = ctrlWord[CTRL_IRQ_EN];
    assign unusedCtrl = ^ctrlWord[DATA_WIDTH-1:CTRL_IRQ_EN+1];

    assign runActive  = (state == RUN);

    mm_timer_prescaler #(
        .DATA_WIDTH(DATA_WIDTH)
    ) prescaler (
        .clock   (clock),
        .reset   (reset),
        .enable  (runActive),
        .prescale(prescaleWord),
        .tick    (tick)
    );

    // Next-state, count and interrupt logic; a match that sets irq wins over irq_clear.
    always_comb begin
        stateNext = state;
        countNext = count;
        irqNext   = irq;
        match     = 1'b0;

        if (irq_clear) begin
            irqNext = 1'b0;
        end

        if (!en) begin
            stateNext = IDLE;
            countNext = '0;
        end else begin
            case (state)
                IDLE: begin
                    stateNext = RUN;
                    countNext = '0;
                end
                RUN: begin
                    if (tick) begin
                        if (count == compareWord) begin
                            match = 1'b1;
                            if (periodic) begin
                                countNext = '0;
                            end else begin
                                stateNext = DONE;
                            end
                        end else begin
                            countNext = count + DATA_WIDTH'(1);
                        end
                    end
                end
                DONE: begin
                    stateNext = DONE;
                end
                default: begin
                    stateNext = IDLE;
                    countNext = '0;
                end
            endcase
        end

        if (match && irqEn) begin
            irqNext = 1'b1;
        end
    end

    // State, count, interrupt and registered running flag.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            count   <= '0;
            irq     <= 1'b0;
            running <= 1'b0;
        end else begin
            state   <= stateNext;
            count   <= countNext;
            irq     <= irqNext;
            running <= (stateNext == RUN);
        end
    end

`ifdef MM_TIMER_CAPTURE_EN
    // Capture register: snapshots the pre-edge count, independent of state.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            capture_value <= '0;
        end else if (capture) begin
            capture_value <= count;
        end
    end
`endif

endmodule

// File: tb/tb_mm_timer.sv
// Testbench for mm_timer: vector table for per-cycle behaviour plus
// hand-written sequences for asynchronous reset and (optionally) capture.
// Honours MM_TIMER_CAPTURE_EN when the DUT is built with it.
module tb_mm_timer;

    localparam int unsigned DW = 32;

    logic          clock = 1'b0;
    logic          reset;
    logic [DW-1:0] ctrl;
    logic [DW-1:0] pre;
    logic [DW-1:0] cmp;
    logic          irqClear;
    logic [DW-1:0] count;
    logic          running;
    logic          irq;
`ifdef MM_TIMER_CAPTURE_EN
    logic          capture;
    logic [DW-1:0] captureValue;
`endif

    int errors = 0;
    int checks = 0;

    mm_timer #(
        .DATA_WIDTH(DW)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .config_regs  ({cmp, pre, ctrl}),
        .irq_clear    (irqClear),
`ifdef MM_TIMER_CAPTURE_EN
        .capture      (capture),
        .capture_value(captureValue),
`endif
        .count        (count),
        .running      (running),
        .irq          (irq)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [DW-1:0] ctrl;
        logic [DW-1:0] pre;
        logic [DW-1:0] cmp;
        logic          clr;
        logic [DW-1:0] eCount;
        logic          eRun;
        logic          eIrq;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic [DW-1:0] c, input logic [DW-1:0] p,
                                input logic [DW-1:0] m, input logic cl,
                                input logic [DW-1:0] ec, input logic er, input logic ei);
        vec_t v;
        v.ctrl = c; v.pre = p; v.cmp = m; v.clr = cl;
        v.eCount = ec; v.eRun = er; v.eIrq = ei;
        return v;
    endfunction

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    initial begin
        bit found;

        // periodic count 0..3 with irq set on wrap, then cleared
        vecs.push_back(mk(7, 0, 3, 0, 0, 1, 0));
        vecs.push_back(mk(7, 0, 3, 0, 1, 1, 0));
        vecs.push_back(mk(7, 0, 3, 0, 2, 1, 0));
        vecs.push_back(mk(7, 0, 3, 0, 3, 1, 0));
        vecs.push_back(mk(7, 0, 3, 0, 0, 1, 1));
        vecs.push_back(mk(7, 0, 3, 0, 1, 1, 1));
        vecs.push_back(mk(7, 0, 3, 1, 2, 1, 0));
        vecs.push_back(mk(7, 0, 3, 0, 3, 1, 0));
        vecs.push_back(mk(7, 0, 3, 0, 0, 1, 1));
        // compare=0 with irq_clear held: set beats clear
        vecs.push_back(mk(7, 0, 0, 1, 0, 1, 1));
        vecs.push_back(mk(7, 0, 0, 1, 0, 1, 1));
        vecs.push_back(mk(7, 0, 0, 1, 0, 1, 1));
        // EN=0 keeps irq, then clear
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 1));
        vecs.push_back(mk(0, 0, 0, 1, 0, 0, 0));
        // IRQ_EN=0 wraps silently; enabling it raises irq on next match
        vecs.push_back(mk(3, 0, 2, 0, 0, 1, 0));
        vecs.push_back(mk(3, 0, 2, 0, 1, 1, 0));
        vecs.push_back(mk(3, 0, 2, 0, 2, 1, 0));
        vecs.push_back(mk(3, 0, 2, 0, 0, 1, 0));
        vecs.push_back(mk(3, 0, 2, 0, 1, 1, 0));
        vecs.push_back(mk(3, 0, 2, 0, 2, 1, 0));
        vecs.push_back(mk(7, 0, 2, 0, 0, 1, 1));
        vecs.push_back(mk(3, 0, 2, 0, 1, 1, 1));
        vecs.push_back(mk(0, 0, 2, 0, 0, 0, 1));
        vecs.push_back(mk(0, 0, 2, 1, 0, 0, 0));
        // one-shot, prescale=4, compare=1
        vecs.push_back(mk(5, 4, 1, 0, 0, 1, 0));
        vecs.push_back(mk(5, 4, 1, 0, 0, 1, 0));
        vecs.push_back(mk(5, 4, 1, 0, 0, 1, 0));
        vecs.push_back(mk(5, 4, 1, 0, 0, 1, 0));
        vecs.push_back(mk(5, 4, 1, 0, 0, 1, 0));
        vecs.push_back(mk(5, 4, 1, 0, 1, 1, 0));
        vecs.push_back(mk(5, 4, 1, 0, 1, 1, 0));
        vecs.push_back(mk(5, 4, 1, 0, 1, 1, 0));
        vecs.push_back(mk(5, 4, 1, 0, 1, 1, 0));
        vecs.push_back(mk(5, 4, 1, 0, 1, 1, 0));
        vecs.push_back(mk(5, 4, 1, 0, 1, 0, 1));
        vecs.push_back(mk(5, 4, 1, 0, 1, 0, 1));
        vecs.push_back(mk(0, 4, 1, 0, 0, 0, 1));

        reset    = 1'b1;
        ctrl     = '0;
        pre      = '0;
        cmp      = '0;
        irqClear = 1'b0;
`ifdef MM_TIMER_CAPTURE_EN
        capture  = 1'b0;
`endif
        #2;
        check("reset_count", count, 0);
        check("reset_running", {31'b0, running}, 0);
        check("reset_irq", {31'b0, irq}, 0);
        @(negedge clock);
        reset = 1'b0;

        foreach (vecs[i]) begin
            ctrl     = vecs[i].ctrl;
            pre      = vecs[i].pre;
            cmp      = vecs[i].cmp;
            irqClear = vecs[i].clr;
            @(negedge clock);
            check($sformatf("v%0d_count", i), count, vecs[i].eCount);
            check($sformatf("v%0d_running", i), {31'b0, running}, {31'b0, vecs[i].eRun});
            check($sformatf("v%0d_irq", i), {31'b0, irq}, {31'b0, vecs[i].eIrq});
        end
        irqClear = 1'b0;

        // asynchronous reset mid-count with irq pending
        ctrl = 7; pre = 2; cmp = 100;
        found = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clock);
            if (count == 7) begin
                found = 1'b1;
                break;
            end
        end
        check("areset_reach7", {31'b0, found}, 1);
        check("areset_irq_before", {31'b0, irq}, 1);
        #2 reset = 1'b1;
        #1;
        check("areset_count", count, 0);
        check("areset_irq", {31'b0, irq}, 0);
        check("areset_running", {31'b0, running}, 0);
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        check("restart_running", {31'b0, running}, 1);
        check("restart_count", count, 0);
        repeat (3) @(negedge clock);
        check("restart_count_tick", count, 1);

`ifdef MM_TIMER_CAPTURE_EN
        // capture the pre-edge count and hold it
        ctrl = 3; pre = 0; cmp = 9;
        found = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clock);
            if (count == 5) begin
                found = 1'b1;
                break;
            end
        end
        check("cap_reach5", {31'b0, found}, 1);
        capture = 1'b1;
        @(negedge clock);
        capture = 1'b0;
        check("cap_value", captureValue, 5);
        check("cap_count", count, 6);
        repeat (2) @(negedge clock);
        check("cap_hold", captureValue, 5);
        check("cap_count_adv", count, 8);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
